// File: rtl/nes_joypad_port.sv
// CPU-side responder for the NES controller ports at $4016/$4017: strobe latch,
// per-port serial shift registers, and vblank-paced turbo A/B.
module nes_joypad_port #(
  parameter int TURBO_FRAMES = 2,
  parameter bit P2_EN        = 1'b1
) (
  input  logic        i_cpu_clk,
  input  logic        i_rstn_nes,
  input  logic        i_bus_en,
  input  logic [15:0] i_bus_addr,
  input  logic        i_bus_wn,
  input  logic [7:0]  i_bus_wdata,
  input  logic        i_vblank,
  input  logic [9:0]  i_jp_vec_1p,
  input  logic [9:0]  i_jp_vec_2p,
  output logic        o_sel,
  output logic [7:0]  o_rdata
);

  localparam logic [3:0] TURBO_LAST = 4'(TURBO_FRAMES - 1);

  logic       addr_p1;
  logic       addr_p2;
  logic       rd_access;
  logic       strobe_wr;
  logic [1:0] port_addr;
  logic [1:0] port_bit;

  logic       strobe_reg;
  logic       strobe_next;
  logic       vblank_d_reg;
  logic       vblank_rise;
  logic [3:0] turbo_cnt_reg;
  logic [3:0] turbo_cnt_next;
  logic       phase_reg;
  logic       phase_next;

  // Only bit 0 of the strobe write carries meaning.
  logic unused_wdata;
  assign unused_wdata = ^i_bus_wdata[7:1];

  assign addr_p1   = (i_bus_addr == 16'h4016);
  assign addr_p2   = (i_bus_addr == 16'h4017);
  assign o_sel     = i_bus_en && (addr_p1 || addr_p2);
  assign rd_access = o_sel && i_bus_wn;
  assign strobe_wr = i_bus_en && !i_bus_wn && addr_p1;
  assign port_addr = {addr_p2, addr_p1};

  assign vblank_rise = i_vblank && !vblank_d_reg;

  always_comb begin
    strobe_next    = strobe_reg;
    turbo_cnt_next = turbo_cnt_reg;
    phase_next     = phase_reg;
    if (strobe_wr) begin
      strobe_next = i_bus_wdata[0];
    end
    if (vblank_rise) begin
      if (turbo_cnt_reg == TURBO_LAST) begin
        turbo_cnt_next = 4'd0;
        phase_next     = !phase_reg;
      end else begin
        turbo_cnt_next = turbo_cnt_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge i_cpu_clk or negedge i_rstn_nes) begin
    if (!i_rstn_nes) begin
      strobe_reg    <= 1'b0;
      vblank_d_reg  <= 1'b0;
      turbo_cnt_reg <= 4'd0;
      phase_reg     <= 1'b0;
    end else begin
      strobe_reg    <= strobe_next;
      vblank_d_reg  <= i_vblank;
      turbo_cnt_reg <= turbo_cnt_next;
      phase_reg     <= phase_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [9:0] vec;
      logic       a_eff;
      logic       b_eff;
      logic [7:0] load_byte;
      logic [7:0] sreg_reg;
      logic [7:0] sreg_next;
      logic       raw_bit;

      assign vec   = (gi == 0) ? i_jp_vec_1p : i_jp_vec_2p;
      assign a_eff = vec[5] | (vec[3] & phase_reg);
      assign b_eff = vec[4] | (vec[2] & phase_reg);
      // Shifted out LSB first: A, B, select, start, up, down, left, right.
      assign load_byte = {vec[6], vec[7], vec[8], vec[9], vec[0], vec[1], b_eff, a_eff};

      always_comb begin
        sreg_next = sreg_reg;
        if (strobe_reg) begin
          sreg_next = load_byte;
        end else if (rd_access && port_addr[gi]) begin
          sreg_next = {1'b1, sreg_reg[7:1]};
        end
      end

      always_ff @(posedge i_cpu_clk or negedge i_rstn_nes) begin
        if (!i_rstn_nes) begin
          sreg_reg <= 8'hFF;
        end else begin
          sreg_reg <= sreg_next;
        end
      end

      assign raw_bit       = strobe_reg ? a_eff : sreg_reg[0];
      assign port_bit[gi]  = (gi == 1 && !P2_EN) ? 1'b0 : raw_bit;
    end
  endgenerate

  always_comb begin
    o_rdata = 8'h40;
    if (rd_access) begin
      o_rdata = {7'b0100000, addr_p2 ? port_bit[1] : port_bit[0]};
    end
  end

endmodule

// File: tb/tb_nes_joypad_port.sv
// Directed self-checking bench for nes_joypad_port (default instance plus a P2_EN=0 instance).
module tb_nes_joypad_port;

  logic        clk;
  logic        rstn;
  logic        bus_en;
  logic [15:0] bus_addr;
  logic        bus_wn;
  logic [7:0]  bus_wdata;
  logic        vblank;
  logic [9:0]  vec_1p;
  logic [9:0]  vec_2p;
  logic        sel;
  logic [7:0]  rdata;
  logic        sel_b;
  logic [7:0]  rdata_b;

  int checks = 0;
  int errors = 0;

  nes_joypad_port #(.TURBO_FRAMES(2), .P2_EN(1'b1)) dut (
    .i_cpu_clk(clk), .i_rstn_nes(rstn), .i_bus_en(bus_en), .i_bus_addr(bus_addr),
    .i_bus_wn(bus_wn), .i_bus_wdata(bus_wdata), .i_vblank(vblank),
    .i_jp_vec_1p(vec_1p), .i_jp_vec_2p(vec_2p), .o_sel(sel), .o_rdata(rdata)
  );

  nes_joypad_port #(.TURBO_FRAMES(2), .P2_EN(1'b0)) dut_p2off (
    .i_cpu_clk(clk), .i_rstn_nes(rstn), .i_bus_en(bus_en), .i_bus_addr(bus_addr),
    .i_bus_wn(bus_wn), .i_bus_wdata(bus_wdata), .i_vblank(vblank),
    .i_jp_vec_1p(vec_1p), .i_jp_vec_2p(vec_2p), .o_sel(sel_b), .o_rdata(rdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic [7:0] d_b,
                          output logic s);
    @(negedge clk);
    bus_en = 1'b1; bus_addr = a; bus_wn = 1'b1;
    #1;
    d = rdata; d_b = rdata_b; s = sel;
    $display("rd  addr=%h data=%h data_p2off=%h", a, d, d_b);
    @(posedge clk);
    #1;
    bus_en = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] wd, output logic [7:0] d,
                           output logic s);
    @(negedge clk);
    bus_en = 1'b1; bus_addr = a; bus_wn = 1'b0; bus_wdata = wd;
    #1;
    d = rdata; s = sel;
    $display("wr  addr=%h wdata=%h", a, wd);
    @(posedge clk);
    #1;
    bus_en = 1'b0; bus_wn = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic strobe_pulse();
    logic [7:0] d;
    logic s;
    bus_write(16'h4016, 8'h01, d, s);
    bus_write(16'h4016, 8'h00, d, s);
  endtask

  task automatic test_reset();
    logic [7:0] d, d_b;
    logic s;
    do_reset();
    #1;
    checks++;
    if (sel !== 1'b0 || rdata !== 8'h40) begin
      errors++;
      $display("FAIL reset_idle: sel=%b rdata=%h required sel=0 rdata=40", sel, rdata);
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(16'h4016, d, d_b, s);
      checks++;
      if (d !== 8'h41 || s !== 1'b1) begin
        errors++;
        $display("FAIL reset_read%0d: rdata=%h sel=%b required 41 sel=1", i, d, s);
      end
    end
  endtask

  task automatic test_serial();
    logic [7:0] d, d_b;
    logic s;
    logic [9:0] exp_bits;
    exp_bits = 10'b11_0000_1000; // read index i -> exp_bits[i]
    vec_1p = 10'b00_0000_0001;
    strobe_pulse();
    for (int i = 0; i < 10; i++) begin
      bus_read(16'h4016, d, d_b, s);
      checks++;
      if (d !== {7'b0100000, exp_bits[i]}) begin
        errors++;
        $display("FAIL serial_start read%0d: rdata=%h required %h", i, d, {7'b0100000, exp_bits[i]});
      end
    end
  endtask

  task automatic test_interleave();
    logic [7:0] d, d_b;
    logic s;
    logic e1, e2;
    vec_1p = 10'b00_0100_0000;
    vec_2p = 10'b10_0000_0000;
    strobe_pulse();
    for (int i = 0; i < 8; i++) begin
      e1 = (i == 7);
      e2 = (i == 4);
      bus_read(16'h4016, d, d_b, s);
      checks++;
      if (d !== {7'b0100000, e1}) begin
        errors++;
        $display("FAIL interleave_p1 read%0d: rdata=%h required %h", i, d, {7'b0100000, e1});
      end
      bus_read(16'h4017, d, d_b, s);
      checks++;
      if (d !== {7'b0100000, e2}) begin
        errors++;
        $display("FAIL interleave_p2 read%0d: rdata=%h required %h", i, d, {7'b0100000, e2});
      end
    end
  endtask

  task automatic test_strobe_held();
    logic [7:0] d, d_b;
    logic s;
    vec_1p = 10'b00_0010_0000;
    bus_write(16'h4016, 8'h01, d, s);
    for (int i = 0; i < 4; i++) begin
      bus_read(16'h4016, d, d_b, s);
      checks++;
      if (d !== 8'h41) begin
        errors++;
        $display("FAIL strobe_held read%0d: rdata=%h required 41", i, d);
      end
    end
    vec_1p = 10'b0;
    bus_read(16'h4016, d, d_b, s);
    checks++;
    if (d !== 8'h40) begin
      errors++;
      $display("FAIL strobe_held_release: rdata=%h required 40", d);
    end
    bus_write(16'h4016, 8'h00, d, s);
  endtask

  task automatic test_turbo();
    logic [7:0] d, d_b;
    logic s;
    logic [7:0] exp_bits;
    exp_bits = 8'b1100_1100; // reload k -> exp_bits[k]
    do_reset();
    vec_1p = 10'b00_0000_1000;
    for (int k = 0; k < 8; k++) begin
      strobe_pulse();
      bus_read(16'h4016, d, d_b, s);
      checks++;
      if (d !== {7'b0100000, exp_bits[k]}) begin
        errors++;
        $display("FAIL turbo reload%0d: rdata=%h required %h", k, d, {7'b0100000, exp_bits[k]});
      end
      @(negedge clk) vblank = 1'b1;
      repeat (2) @(negedge clk);
      vblank = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_p2_off();
    logic [7:0] d, d_b;
    logic s;
    vec_1p = 10'b00_0010_0000;
    vec_2p = 10'b11_1111_1111;
    strobe_pulse();
    for (int i = 0; i < 8; i++) begin
      bus_read(16'h4017, d, d_b, s);
      checks++;
      if (d_b !== 8'h40 || d !== 8'h41) begin
        errors++;
        $display("FAIL p2_off read%0d: p2off=%h main=%h required 40 / 41", i, d_b, d);
      end
    end
    bus_write(16'h4017, 8'h01, d, s);
    checks++;
    if (s !== 1'b1 || d !== 8'h40) begin
      errors++;
      $display("FAIL write_4017_bus: sel=%b rdata=%h required sel=1 rdata=40", s, d);
    end
    bus_read(16'h4016, d, d_b, s);
    checks++;
    if (d !== 8'h41) begin
      errors++;
      $display("FAIL write_4017_first: rdata=%h required 41", d);
    end
    bus_read(16'h4016, d, d_b, s);
    checks++;
    if (d !== 8'h40) begin
      errors++;
      $display("FAIL write_4017_strobe_unchanged: rdata=%h required 40", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d, d_b;
    logic s;
    vec_1p = 10'b0;
    strobe_pulse();
    for (int i = 0; i < 3; i++) begin
      bus_read(16'h4016, d, d_b, s);
      checks++;
      if (d !== 8'h40) begin
        errors++;
        $display("FAIL reset_mid_pre read%0d: rdata=%h required 40", i, d);
      end
    end
    do_reset();
    bus_read(16'h4016, d, d_b, s);
    checks++;
    if (d !== 8'h41) begin
      errors++;
      $display("FAIL reset_mid_post: rdata=%h required 41", d);
    end
  endtask

  initial begin
    rstn = 1'b0; bus_en = 1'b0; bus_addr = 16'h0000; bus_wn = 1'b1; bus_wdata = 8'h00;
    vblank = 1'b0; vec_1p = 10'b0; vec_2p = 10'b0;
    test_reset();
    test_serial();
    test_interleave();
    test_strobe_held();
    test_turbo();
    test_p2_off();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
